// File: rtl/cam_controller.sv
// Command sequencer for a CAM array: SEARCH/INSERT/DELETE/CLEAR with per-row valid
// bits kept here, since the array itself has no notion of an empty row.
module cam_controller #(
  parameter int CAM_WIDTH = 8,
  parameter int CAM_DEPTH = 8,
  localparam int ADDR_W   = $clog2(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CAM_WIDTH-1:0] cmd_word,
  input  logic [CAM_WIDTH-1:0] cmd_mask,
  input  logic [ADDR_W-1:0]    cmd_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic                 rsp_multi,
  output logic [ADDR_W-1:0]    rsp_addr,
  output logic [1:0]           rsp_status,
  output logic [CAM_DEPTH-1:0] cam_we,
  output logic [CAM_WIDTH-1:0] cam_search_word,
  output logic [CAM_WIDTH-1:0] cam_dont_care_mask,
  input  logic [CAM_DEPTH-1:0] cam_match,
  output logic [ADDR_W:0]      occupancy,
  output logic                 full
);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DUP     = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_BADADDR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_CAPTURE, S_WRITE, S_UPDATE, S_RESP
  } state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_op;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_free;
  logic [CAM_DEPTH-1:0]  r_valid;

  logic                  w_accept;
  logic [CAM_DEPTH-1:0]  w_m;
  logic                  w_hit;
  logic                  w_multi;
  logic                  w_all_valid;
  logic [ADDR_W-1:0]     w_idx;
  logic [ADDR_W-1:0]     w_free;
  logic [ADDR_W:0]       w_count;

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_accept    = cmd_valid && cmd_ready;

  // Stale array contents are hidden by gating matches with the valid bits.
  assign w_m         = cam_match & r_valid;
  assign w_hit       = |w_m;
  assign w_multi     = |(w_m & (w_m - CAM_DEPTH'(1)));
  assign w_all_valid = &r_valid;

  always_comb begin
    w_idx  = '0;
    w_free = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (w_m[i])      w_idx  = ADDR_W'(i);
      if (!r_valid[i]) w_free = ADDR_W'(i);
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < CAM_DEPTH; i++) w_count = w_count + (ADDR_W + 1)'(r_valid[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (cmd_op == OP_SEARCH || cmd_op == OP_INSERT) ? S_DRIVE : S_UPDATE;
      end
      S_DRIVE:   w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (r_op == OP_INSERT && !w_hit && !w_all_valid) w_next = S_WRITE;
        else                                             w_next = S_RESP;
      end
      S_WRITE:   w_next = S_RESP;
      S_UPDATE:  w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op               <= OP_SEARCH;
      r_addr             <= '0;
      r_free             <= '0;
      r_valid            <= '0;
      rsp_valid          <= 1'b0;
      rsp_hit            <= 1'b0;
      rsp_multi          <= 1'b0;
      rsp_addr           <= '0;
      rsp_status         <= ST_OK;
      cam_we             <= '0;
      cam_search_word    <= '0;
      cam_dont_care_mask <= '0;
      occupancy          <= '0;
      full               <= 1'b0;
    end else begin
      cam_we    <= '0;
      occupancy <= w_count;
      full      <= w_all_valid;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= cmd_op;
            r_addr <= cmd_addr;
            // INSERT searches with no don't-cares so DUP means an exact duplicate.
            if (cmd_op == OP_SEARCH || cmd_op == OP_INSERT) begin
              cam_search_word    <= cmd_word;
              cam_dont_care_mask <= (cmd_op == OP_SEARCH) ? cmd_mask : '0;
            end
          end
        end
        S_CAPTURE: begin
          if (r_op == OP_SEARCH) begin
            rsp_valid  <= 1'b1;
            rsp_hit    <= w_hit;
            rsp_multi  <= w_multi;
            rsp_addr   <= w_idx;
            rsp_status <= ST_OK;
          end else if (w_hit) begin
            rsp_valid  <= 1'b1;
            rsp_hit    <= 1'b1;
            rsp_multi  <= w_multi;
            rsp_addr   <= w_idx;
            rsp_status <= ST_DUP;
          end else if (w_all_valid) begin
            rsp_valid  <= 1'b1;
            rsp_hit    <= 1'b0;
            rsp_multi  <= 1'b0;
            rsp_addr   <= '0;
            rsp_status <= ST_FULL;
          end else begin
            cam_we <= CAM_DEPTH'(1) << w_free;
            r_free <= w_free;
          end
        end
        S_WRITE: begin
          r_valid[r_free] <= 1'b1;
          rsp_valid       <= 1'b1;
          rsp_hit         <= 1'b0;
          rsp_multi       <= 1'b0;
          rsp_addr        <= r_free;
          rsp_status      <= ST_OK;
        end
        S_UPDATE: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_multi <= 1'b0;
          if (r_op == OP_DELETE) begin
            rsp_addr <= r_addr;
            if (r_valid[r_addr]) begin
              r_valid[r_addr] <= 1'b0;
              rsp_status      <= ST_OK;
            end else begin
              rsp_status      <= ST_BADADDR;
            end
          end else begin
            r_valid    <= '0;
            rsp_addr   <= '0;
            rsp_status <= ST_OK;
          end
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_controller.sv
// Directed bench for cam_controller with a small behavioural CAM array attached.
module tb_cam_controller;
  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_word = '0;
  logic [W-1:0] cmd_mask = '0;
  logic [A-1:0] cmd_addr = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_hit, rsp_multi;
  logic [A-1:0] rsp_addr;
  logic [1:0]   rsp_status;
  logic [D-1:0] cam_we;
  logic [W-1:0] cam_search_word, cam_dont_care_mask;
  logic [D-1:0] cam_match;
  logic [A:0]   occupancy;
  logic         full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_controller #(.CAM_WIDTH(W), .CAM_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_word(cmd_word), .cmd_mask(cmd_mask), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_multi(rsp_multi),
    .rsp_addr(rsp_addr), .rsp_status(rsp_status), .cam_we(cam_we),
    .cam_search_word(cam_search_word), .cam_dont_care_mask(cam_dont_care_mask),
    .cam_match(cam_match), .occupancy(occupancy), .full(full)
  );

  // Array model: rows written on cam_we, combinational masked match.
  logic [W-1:0] mem [D];
  initial for (int i = 0; i < D; i++) mem[i] = '0;
  always @(posedge clk) for (int i = 0; i < D; i++) if (cam_we[i]) mem[i] <= cam_search_word;
  always_comb
    for (int i = 0; i < D; i++)
      cam_match[i] = (((mem[i] ^ cam_search_word) & ~cam_dont_care_mask) == '0);

  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] w, input logic [W-1:0] m,
                        input logic [A-1:0] a, output logic [1:0] st, output logic h,
                        output logic mu, output logic [A-1:0] ra, output int lat,
                        output logic [D-1:0] we_or, output int we_n);
    int i;
    we_or = '0; we_n = 0; lat = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_word = w; cmd_mask = m; cmd_addr = a;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (i = 1; i < 20; i++) begin
      if (i > 1) @(negedge clk);
      if (cam_we != '0) begin we_or = we_or | cam_we; we_n++; end
      if (rsp_valid) break;
    end
    lat = i;
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout op=%0d: no rsp_valid within 20 cycles", op);
    end
    st = rsp_status; h = rsp_hit; mu = rsp_multi; ra = rsp_addr;
    @(posedge clk);
  endtask

  logic [1:0]   st;
  logic         h, mu;
  logic [A-1:0] ra;
  int           lat, we_n;
  logic [D-1:0] we_or;

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (cam_we !== 8'h00) begin errors++; $display("FAIL reset_cam_we got %h exp 00", cam_we); end
    checks++; if (cam_search_word !== 8'h00 || cam_dont_care_mask !== 8'h00) begin errors++;
      $display("FAIL reset_search got %h/%h exp 00/00", cam_search_word, cam_dont_care_mask); end
    checks++; if (occupancy !== 4'd0 || full !== 1'b0) begin errors++;
      $display("FAIL reset_occ got %0d/%b exp 0/0", occupancy, full); end
  endtask

  task automatic test_insert();
    do_cmd(2'b01, 8'h3C, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd0 || h !== 1'b0) begin errors++;
      $display("FAIL ins1 got st=%0d addr=%0d hit=%b exp 0/0/0", st, ra, h); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ins1_latency got %0d exp 4", lat); end
    checks++; if (we_or !== 8'h01 || we_n !== 1) begin errors++;
      $display("FAIL ins1_we got %h x%0d exp 01 x1", we_or, we_n); end
    do_cmd(2'b01, 8'h5A, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd1) begin errors++;
      $display("FAIL ins2 got st=%0d addr=%0d exp 0/1", st, ra); end
    checks++; if (we_or !== 8'h02 || we_n !== 1) begin errors++;
      $display("FAIL ins2_we got %h x%0d exp 02 x1", we_or, we_n); end
    @(negedge clk);
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL ins_occ got %0d exp 2", occupancy); end
  endtask

  task automatic test_dup();
    do_cmd(2'b01, 8'h3C, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b01 || ra !== 3'd0 || h !== 1'b1) begin errors++;
      $display("FAIL dup got st=%0d addr=%0d hit=%b exp 1/0/1", st, ra, h); end
    checks++; if (lat !== 3 || we_n !== 0) begin errors++;
      $display("FAIL dup_timing got lat=%0d we=%0d exp 3/0", lat, we_n); end
    @(negedge clk);
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL dup_occ got %0d exp 2", occupancy); end
  endtask

  task automatic test_search();
    do_cmd(2'b00, 8'h38, 8'h04, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (h !== 1'b1 || mu !== 1'b0 || ra !== 3'd0 || st !== 2'b00) begin errors++;
      $display("FAIL srch_mask got hit=%b multi=%b addr=%0d st=%0d exp 1/0/0/0", h, mu, ra, st); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL srch_latency got %0d exp 3", lat); end
    do_cmd(2'b00, 8'h00, 8'hFF, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (h !== 1'b1 || mu !== 1'b1 || ra !== 3'd0) begin errors++;
      $display("FAIL srch_all got hit=%b multi=%b addr=%0d exp 1/1/0", h, mu, ra); end
    do_cmd(2'b00, 8'h5A, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (h !== 1'b1 || mu !== 1'b0 || ra !== 3'd1) begin errors++;
      $display("FAIL srch_row1 got hit=%b multi=%b addr=%0d exp 1/0/1", h, mu, ra); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 6; k++) begin
      do_cmd(2'b01, 8'(k + 1), 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
      checks++; if (st !== 2'b00 || ra !== 3'(k + 2)) begin errors++;
        $display("FAIL fill%0d got st=%0d addr=%0d exp 0/%0d", k, st, ra, k + 2); end
    end
    @(negedge clk);
    checks++; if (occupancy !== 4'd8 || full !== 1'b1) begin errors++;
      $display("FAIL full_flag got occ=%0d full=%b exp 8/1", occupancy, full); end
    do_cmd(2'b01, 8'h77, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b10 || ra !== 3'd0 || h !== 1'b0 || lat !== 3 || we_n !== 0) begin errors++;
      $display("FAIL ins_full got st=%0d addr=%0d hit=%b lat=%0d we=%0d exp 2/0/0/3/0", st, ra, h, lat, we_n); end
    do_cmd(2'b10, 8'h00, 8'h00, 3'd3, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd3 || lat !== 2) begin errors++;
      $display("FAIL del3 got st=%0d addr=%0d lat=%0d exp 0/3/2", st, ra, lat); end
    @(negedge clk);
    checks++; if (full !== 1'b0 || occupancy !== 4'd7) begin errors++;
      $display("FAIL del3_flags got full=%b occ=%0d exp 0/7", full, occupancy); end
    do_cmd(2'b01, 8'h77, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd3 || we_or !== 8'h08) begin errors++;
      $display("FAIL refill got st=%0d addr=%0d we=%h exp 0/3/08", st, ra, we_or); end
  endtask

  task automatic test_delete_clear();
    do_cmd(2'b10, 8'h00, 8'h00, 3'd5, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd5) begin errors++;
      $display("FAIL del5a got st=%0d addr=%0d exp 0/5", st, ra); end
    do_cmd(2'b10, 8'h00, 8'h00, 3'd5, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b11 || ra !== 3'd5) begin errors++;
      $display("FAIL del5b got st=%0d addr=%0d exp 3/5", st, ra); end
    do_cmd(2'b11, 8'h00, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd0 || lat !== 2) begin errors++;
      $display("FAIL clear got st=%0d addr=%0d lat=%0d exp 0/0/2", st, ra, lat); end
    do_cmd(2'b00, 8'h3C, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (h !== 1'b0 || ra !== 3'd0 || mu !== 1'b0) begin errors++;
      $display("FAIL srch_cleared got hit=%b addr=%0d multi=%b exp 0/0/0", h, ra, mu); end
    @(negedge clk);
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL clear_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_backpressure();
    int i;
    do_cmd(2'b01, 8'hC3, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (st !== 2'b00 || ra !== 3'd0) begin errors++;
      $display("FAIL bp_ins got st=%0d addr=%0d exp 0/0", st, ra); end
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_word = 8'hC3; cmd_mask = 8'h00; cmd_addr = 3'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got rsp_valid=%b exp 1", rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_addr !== 3'd0 || rsp_status !== 2'b00 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b hit=%b addr=%0d st=%0d rdy=%b exp 1/1/0/0/0",
                 k, rsp_valid, rsp_hit, rsp_addr, rsp_status, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release got v=%b rdy=%b exp 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_reset_mid_write();
    int  i;
    logic seen_bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_word = 8'h99; cmd_mask = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (i = 0; i < 10 && cam_we == '0; i++) @(negedge clk);
    checks++; if (cam_we !== 8'h02) begin errors++; $display("FAIL rw_we got %h exp 02", cam_we); end
    rst = 1'b1;
    #1;
    checks++; if (cam_we !== 8'h00 || rsp_valid !== 1'b0 || occupancy !== 4'd0) begin errors++;
      $display("FAIL rw_async got we=%h v=%b occ=%0d exp 00/0/0", cam_we, rsp_valid, occupancy); end
    @(negedge clk); rst = 1'b0;
    seen_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cam_we !== 8'h00 || cmd_ready !== 1'b1) seen_bad = 1'b1;
    end
    checks++; if (seen_bad !== 1'b0) begin errors++; $display("FAIL rw_quiet got activity after reset exp none"); end
    do_cmd(2'b00, 8'hC3, 8'h00, 3'd0, st, h, mu, ra, lat, we_or, we_n);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL rw_valid_clr got hit=%b exp 0", h); end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_dup();
    test_search();
    test_full();
    test_delete_clear();
    test_backpressure();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cam_controller.md
Name: cam_controller

Overview:
Sequencing controller for the CAM array datapath (CAM_WIDTH x CAM_DEPTH, decoded write enables, search word with don't-care mask, decoded match vector). It accepts SEARCH, INSERT, DELETE and CLEAR commands over a valid/ready handshake. It drives the array's write-enable, search-word and mask inputs, and keeps per-row valid bits, because the array itself has none. It returns a priority-encoded result over a valid/ready response channel.

Parameters:
CAM_WIDTH, 8, stored/search word width (must match array)
CAM_DEPTH, 8, number of rows (power of 2, >=2); ADDR_W = clog2(CAM_DEPTH) derived locally

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  2  00 SEARCH, 01 INSERT, 10 DELETE, 11 CLEAR
cmd_word  input  CAM_WIDTH  search/insert data
cmd_mask  input  CAM_WIDTH  don't-care mask, 1 = ignore bit (SEARCH only)
cmd_addr  input  ADDR_W  row to delete (DELETE only)
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_hit  output  1  at least one valid row matched
rsp_multi  output  1  two or more valid rows matched
rsp_addr  output  ADDR_W  lowest matching row (SEARCH), written or duplicate row (INSERT), cmd_addr (DELETE)
rsp_status  output  2  00 OK, 01 DUP, 10 FULL, 11 BADADDR
cam_we  output  CAM_DEPTH  to array we_decoded_row_address
cam_search_word  output  CAM_WIDTH  to array search_word (also write data)
cam_dont_care_mask  output  CAM_WIDTH  to array dont_care_mask
cam_match  input  CAM_DEPTH  from array decoded_match_address
occupancy  output  ADDR_W+1  number of valid rows
full  output  1  occupancy == CAM_DEPTH

Behaviour:
- Reset (async, immediate): state=IDLE; valid bits=0; every registered output 0: cmd_ready=1 after reset release, rsp_*=0, cam_we=0, cam_search_word=0, cam_dont_care_mask=0, occupancy=0, full=0. Array contents are not cleared. Stale rows are never reported because matches are ANDed with valid bits.
- Reset during any state aborts the command. No response is issued and no write occurs after rst rises.
- FSM states: IDLE, DRIVE, CAPTURE, WRITE, UPDATE, RESP.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op/word/mask/addr.
  - SEARCH/INSERT -> DRIVE.
  - DELETE/CLEAR -> UPDATE.
- DRIVE: cam_search_word=latched word. cam_dont_care_mask=latched mask for SEARCH, all-zeros for INSERT (exact-match duplicate check). Both are held stable until the return to IDLE. Next state is CAPTURE, which allows one full cycle for the array's match logic.
- CAPTURE: m = cam_match & valid. hit=|m; multi = popcount(m)>=2; idx = lowest set bit of m. Lowest free row = lowest clear valid bit.
  - SEARCH -> RESP (status OK, addr=idx, or 0 if no hit).
  - INSERT with hit -> RESP, status DUP, addr=idx, no write.
  - INSERT with full -> RESP, status FULL, addr=0, hit=0.
  - Otherwise -> WRITE.
- WRITE: cam_we = onehot(free row) for exactly one cycle; valid[row] set at end of cycle. -> RESP, status OK, addr=row, hit=0.
- UPDATE:
  - DELETE: if valid[addr], clear it, status OK; else status BADADDR. addr=cmd_addr.
  - CLEAR: all valid bits cleared, status OK, addr=0.
  - -> RESP.
- RESP: rsp_valid=1, fields stable until rsp_valid&rsp_ready, then -> IDLE. cmd_ready=0 throughout.
- cam_we is 0 in every state except WRITE; at most one bit is ever set.
- Latency from accept edge to rsp_valid high: SEARCH 3 cycles, INSERT 4 (OK) or 3 (DUP/FULL), DELETE/CLEAR 2.
- occupancy and full are registered and update in the cycle after the valid-bit change.
- Only one command is in flight; no pipelining.

Test Plan:
- After reset: INSERT 0x3C, then 0x5A -> status OK, addr 0 then 1; cam_we=0x01 then 0x02 for one cycle each; occupancy=2.
- INSERT 0x3C again -> status DUP, addr 0, no cam_we pulse, occupancy stays 2.
- SEARCH word 0x38, mask 0x04 -> hit=1, addr 0, multi=0. SEARCH word 0x00, mask 0xFF -> hit=1, multi=1, addr 0.
- Fill all 8 rows, INSERT 0x77 -> status FULL, full=1. DELETE addr 3 -> OK, full=0. INSERT 0x77 -> OK, addr 3.
- DELETE addr 5 twice -> OK then BADADDR. CLEAR, then SEARCH 0x3C mask 0 -> hit=0, occupancy=0.
- Hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0. Assert rst mid-WRITE -> cam_we=0 immediately, valid bits clear, no response.
